// File: rtl/key_param_ctrl.sv
// key_param_ctrl: turns debounced active-low key pulses into a parameter-edit /
// run-control state machine with two saturating (or wrapping) setpoints.
//
// Build option: define KEY_WRAP_EN to make INC/DEC wrap between MIN_VAL and
// MAX_VAL instead of saturating.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   key_value  debounced keys, active-low, idle 4'b1111
//              bit0=MODE, bit1=INC, bit2=DEC, bit3=CONFIRM
//   mode       current state: 0 IDLE, 1 EDIT_A, 2 EDIT_B, 3 RUN
//   param_a    setpoint A
//   param_b    setpoint B
//   start      one-cycle pulse on entry to RUN
//   done       one-cycle pulse when RUN times out
//   busy       high while mode==RUN
module key_param_ctrl #(
    parameter int unsigned DW       = 8,
    parameter int unsigned MIN_VAL  = 1,
    parameter int unsigned MAX_VAL  = 100,
    parameter int unsigned STEP     = 5,
    parameter int unsigned INIT_A   = 20,
    parameter int unsigned INIT_B   = 50,
    parameter int unsigned RUN_TIME = 1000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    key_value,
    output logic [1:0]    mode,
    output logic [DW-1:0] param_a,
    output logic [DW-1:0] param_b,
    output logic          start,
    output logic          done,
    output logic          busy
);

    localparam int unsigned AW = DW + 1;
    localparam int unsigned CW = $clog2(RUN_TIME);

    localparam logic [AW-1:0] MAX_W  = AW'(MAX_VAL);
    localparam logic [AW-1:0] MIN_W  = AW'(MIN_VAL);
    localparam logic [AW-1:0] STEP_W = AW'(STEP);
    localparam logic [DW-1:0] MAX_P  = DW'(MAX_VAL);
    localparam logic [DW-1:0] MIN_P  = DW'(MIN_VAL);
    localparam logic [DW-1:0] STEP_P = DW'(STEP);
    localparam logic [DW-1:0] INIT_A_P = DW'(INIT_A);
    localparam logic [DW-1:0] INIT_B_P = DW'(INIT_B);
    localparam logic [CW-1:0] LAST_CNT = CW'(RUN_TIME - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT_A = 2'd1,
        EDIT_B = 2'd2,
        RUN    = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [3:0]    key_d;
    logic [3:0]    ev;
    logic [CW-1:0] cnt, cnt_n;
    logic [DW-1:0] a_n, b_n;
    logic          start_n, done_n, busy_n;

    logic [DW-1:0] sel;
    logic [AW-1:0] sel_ext, inc_sum;
    logic [DW-1:0] inc_res, dec_res;

    // Falling edge of an active-low key = one event per press
    assign ev   = key_d & ~key_value;
    assign mode = state;

    // INC/DEC result for whichever setpoint is being edited
    always_comb begin
        sel     = (state == EDIT_B) ? param_b : param_a;
        sel_ext = {1'b0, sel};
        inc_sum = sel_ext + STEP_W;
`ifdef KEY_WRAP_EN
        inc_res = (inc_sum > MAX_W) ? MIN_P : inc_sum[DW-1:0];
        dec_res = (sel_ext < (MIN_W + STEP_W)) ? MAX_P : (sel - STEP_P);
`else
        inc_res = (inc_sum > MAX_W) ? MAX_P : inc_sum[DW-1:0];
        dec_res = (sel_ext < (MIN_W + STEP_W)) ? MIN_P : (sel - STEP_P);
`endif
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            key_d   <= 4'b1111;
            cnt     <= '0;
            param_a <= INIT_A_P;
            param_b <= INIT_B_P;
            start   <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            key_d   <= key_value;
            cnt     <= cnt_n;
            param_a <= a_n;
            param_b <= b_n;
            start   <= start_n;
            done    <= done_n;
            busy    <= busy_n;
        end
    end

    // Next state; only the highest-priority event acts (MODE > INC > DEC > CONFIRM)
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        a_n     = param_a;
        b_n     = param_b;
        start_n = 1'b0;
        done_n  = 1'b0;
        busy_n  = 1'b0;

        if (state == RUN) begin
            cnt_n = cnt + CW'(1);
            if (ev[0]) begin
                state_n = IDLE;             // abort wins over timeout
            end else if (cnt == LAST_CNT) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
        end else if (ev[0]) begin
            case (state)
                IDLE:    state_n = EDIT_A;
                EDIT_A:  state_n = EDIT_B;
                default: state_n = IDLE;
            endcase
        end else if (ev[1] || ev[2]) begin
            // IDLE ignores INC/DEC; lower-priority events are dropped regardless
            if (state == EDIT_A) begin
                a_n = ev[1] ? inc_res : dec_res;
            end else if (state == EDIT_B) begin
                b_n = ev[1] ? inc_res : dec_res;
            end
        end else if (ev[3]) begin
            state_n = RUN;
            start_n = 1'b1;
            cnt_n   = '0;
        end

        busy_n = (state_n == RUN);
    end

endmodule

// File: tb/tb_key_param_ctrl.sv
// Self-checking bench for key_param_ctrl: a vector table for single-cycle
// behaviour plus hand-written sequences for saturation and RUN timing.
module tb_key_param_ctrl;

    localparam logic [3:0] K_IDLE = 4'b1111;
    localparam logic [3:0] K_MODE = 4'b1110;
    localparam logic [3:0] K_INC  = 4'b1101;
    localparam logic [3:0] K_DEC  = 4'b1011;
    localparam logic [3:0] K_CONF = 4'b0111;
    localparam logic [3:0] K_M_I  = 4'b1100;

    logic       clk;
    logic       rst;
    logic [3:0] key_value;
    logic [1:0] mode;
    logic [7:0] param_a, param_b;
    logic       start, done, busy;

    int n_cmp  = 0;
    int n_fail = 0;

    key_param_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .key_value (key_value),
        .mode      (mode),
        .param_a   (param_a),
        .param_b   (param_b),
        .start     (start),
        .done      (done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [3:0] kv;
        int         mode;
        int         a;
        int         b;
        int         start;
        int         done;
        int         busy;
    } vec_t;

    vec_t vt [29];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] kv);
        key_value = kv;
        @(posedge clk);
        #1;
    endtask

    function automatic int inc_m(input int p);
`ifdef KEY_WRAP_EN
        return (p + 5 > 100) ? 1 : p + 5;
`else
        return (p + 5 > 100) ? 100 : p + 5;
`endif
    endfunction

    function automatic int dec_m(input int p);
`ifdef KEY_WRAP_EN
        return (p < 6) ? 100 : p - 5;
`else
        return (p < 6) ? 1 : p - 5;
`endif
    endfunction

    task automatic check_all(input string tag, input int m, input int a, input int b,
                             input int s, input int d, input int bz);
        check({tag, ".mode"},  int'(mode),    m);
        check({tag, ".a"},     int'(param_a), a);
        check({tag, ".b"},     int'(param_b), b);
        check({tag, ".start"}, int'(start),   s);
        check({tag, ".done"},  int'(done),    d);
        check({tag, ".busy"},  int'(busy),    bz);
    endtask

    initial begin
        int exp_a, exp_b, n;
        bit seen_done;

        rst       = 1'b1;
        key_value = K_IDLE;

        //          rst   key     mode a   b   st dn bz
        vt[0]  = '{1'b1, K_IDLE, 0,  20, 50, 0, 0, 0};
        vt[1]  = '{1'b0, K_MODE, 1,  20, 50, 0, 0, 0};
        vt[2]  = '{1'b0, K_IDLE, 1,  20, 50, 0, 0, 0};
        vt[3]  = '{1'b0, K_INC,  1,  25, 50, 0, 0, 0};
        vt[4]  = '{1'b0, K_IDLE, 1,  25, 50, 0, 0, 0};
        vt[5]  = '{1'b0, K_INC,  1,  30, 50, 0, 0, 0};
        vt[6]  = '{1'b0, K_IDLE, 1,  30, 50, 0, 0, 0};
        vt[7]  = '{1'b0, K_INC,  1,  35, 50, 0, 0, 0};
        vt[8]  = '{1'b0, K_IDLE, 1,  35, 50, 0, 0, 0};
        vt[9]  = '{1'b0, K_DEC,  1,  30, 50, 0, 0, 0};
        vt[10] = '{1'b0, K_IDLE, 1,  30, 50, 0, 0, 0};
        vt[11] = '{1'b0, K_M_I,  2,  30, 50, 0, 0, 0};
        vt[12] = '{1'b0, K_IDLE, 2,  30, 50, 0, 0, 0};
        vt[13] = '{1'b0, K_DEC,  2,  30, 45, 0, 0, 0};
        vt[14] = '{1'b0, K_IDLE, 2,  30, 45, 0, 0, 0};
        vt[15] = '{1'b0, K_CONF, 3,  30, 45, 1, 0, 1};
        vt[16] = '{1'b0, K_IDLE, 3,  30, 45, 0, 0, 1};
        vt[17] = '{1'b0, K_INC,  3,  30, 45, 0, 0, 1};
        vt[18] = '{1'b0, K_IDLE, 3,  30, 45, 0, 0, 1};
        vt[19] = '{1'b0, K_MODE, 0,  30, 45, 0, 0, 0};
        vt[20] = '{1'b0, K_IDLE, 0,  30, 45, 0, 0, 0};
        vt[21] = '{1'b0, K_M_I,  1,  30, 45, 0, 0, 0};
        vt[22] = '{1'b0, K_IDLE, 1,  30, 45, 0, 0, 0};
        vt[23] = '{1'b0, K_INC,  1,  35, 45, 0, 0, 0};
        vt[24] = '{1'b0, K_INC,  1,  35, 45, 0, 0, 0};
        vt[25] = '{1'b0, K_INC,  1,  35, 45, 0, 0, 0};
        vt[26] = '{1'b0, K_INC,  1,  35, 45, 0, 0, 0};
        vt[27] = '{1'b0, K_INC,  1,  35, 45, 0, 0, 0};
        vt[28] = '{1'b0, K_IDLE, 1,  35, 45, 0, 0, 0};

        for (int i = 0; i < 29; i++) begin
            rst = vt[i].r;
            step(vt[i].kv);
            check_all($sformatf("vec%0d", i), vt[i].mode, vt[i].a, vt[i].b,
                      vt[i].start, vt[i].done, vt[i].busy);
        end

        // Saturation (or wrap) of param_a over 20 INC pulses
        rst = 1'b1;
        step(K_IDLE);
        rst = 1'b0;
        check_all("rst2", 0, 20, 50, 0, 0, 0);
        step(K_MODE);
        step(K_IDLE);
        exp_a = 20;
        exp_b = 50;
        for (int i = 0; i < 20; i++) begin
            step(K_INC);
            exp_a = inc_m(exp_a);
            check($sformatf("inc%0d.a", i + 1), int'(param_a), exp_a);
            step(K_IDLE);
        end

        // param_b floor over 15 DEC pulses
        step(K_MODE);
        step(K_IDLE);
        check("to_edit_b", int'(mode), 2);
        for (int i = 0; i < 15; i++) begin
            step(K_DEC);
            exp_b = dec_m(exp_b);
            check($sformatf("dec%0d.b", i + 1), int'(param_b), exp_b);
            step(K_IDLE);
        end

        // Full RUN: start, 1000 busy cycles, done; INC pulses ignored
        step(K_CONF);
        check_all("run_entry", 3, exp_a, exp_b, 1, 0, 1);
        n = 1;
        seen_done = 1'b0;
        while (mode == 2'd3 && n < 1100) begin
            step((n == 10 || n == 12) ? K_INC : K_IDLE);
            if (mode == 2'd3) begin
                n++;
                if (start !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
                    check($sformatf("run_cyc%0d.st_dn_bz", n), {29'd0, start, done, busy}, 1);
                end
            end else begin
                seen_done = done;
            end
        end
        check("run_len", n, 1000);
        check("run_done", int'(seen_done), 1);
        check_all("run_exit", 0, exp_a, exp_b, 0, 1, 0);
        step(K_IDLE);
        check("done_one_cycle", int'(done), 0);

        // Abort at RUN cycle 500: back to IDLE, no done ever
        step(K_CONF);
        check("abort_start", int'(start), 1);
        for (int i = 0; i < 499; i++) step(K_IDLE);
        check("abort_c500_mode", int'(mode), 3);
        step(K_MODE);
        check_all("abort", 0, exp_a, exp_b, 0, 0, 0);
        seen_done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            step(K_IDLE);
            if (done === 1'b1) seen_done = 1'b1;
        end
        check("abort_no_done", int'(seen_done), 0);

        // MODE on the final RUN cycle: abort beats timeout
        step(K_CONF);
        for (int i = 0; i < 999; i++) step(K_IDLE);
        check("last_cyc_mode", int'(mode), 3);
        step(K_MODE);
        check_all("last_abort", 0, exp_a, exp_b, 0, 0, 0);
        step(K_IDLE);
        check("last_abort_no_done", int'(done), 0);

        // Reset mid-RUN
        step(K_CONF);
        for (int i = 0; i < 20; i++) step(K_IDLE);
        check("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        step(K_IDLE);
        check_all("mid_rst", 0, 20, 50, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(K_IDLE);
        check_all("post_rst", 0, 20, 50, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
